// File: rtl/axi4s_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream arbiter.
package axi4s_arb_pkg;

  // Upper bound on the number of sources that rr_pick can search.
  localparam int MAX_SRC = 16;

  // Arbiter state:
  //   state   | meaning
  //   ST_IDLE | no grant held; round-robin search over requesters this cycle
  //   ST_BUSY | grant locked to one source until its tlast beat is accepted
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req searching ptr+1, ptr+2, ... modulo n_src.
  // Done as two linear passes (above ptr, then up to and including ptr)
  // so no modulo arithmetic is needed.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [3:0]         ptr,
                                       input int                 n_src);
    rr_pick_t res;
    res = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (!res.found && (i < n_src) && (i > int'(ptr)) && req[i]) begin
        res.found = 1'b1;
        res.idx   = 4'(i);
      end
    end
    for (int i = 0; i < MAX_SRC; i++) begin
      if (!res.found && (i <= int'(ptr)) && req[i]) begin
        res.found = 1'b1;
        res.idx   = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer for an AXI4-Stream channel. Outputs are registered,
// input ready is registered (high whenever the skid entry is empty), and the
// slice sustains one beat per cycle while the downstream side is ready.
module axis_reg_slice #(
  parameter int DATA_W = 64,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [USER_W-1:0] out_user_q, out_user_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [USER_W-1:0] skid_user_q, skid_user_d;
  logic              skid_last_q, skid_last_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              s_hs;

  // Next-state: refill the output register from the skid entry first, else
  // straight from the input; park the input beat in the skid when stalled.
  always_comb begin
    out_data_d   = out_data_q;
    out_user_d   = out_user_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_user_d  = skid_user_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    s_hs         = s_tvalid && in_ready_q;

    if (!out_valid_q || m_tready) begin
      if (skid_valid_q) begin
        // Input ready was low this cycle, so no new beat can collide here.
        out_data_d   = skid_data_q;
        out_user_d   = skid_user_q;
        out_last_d   = skid_last_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_hs;
        if (s_hs) begin
          out_data_d = s_tdata;
          out_user_d = s_tuser;
          out_last_d = s_tlast;
        end
      end
    end else if (s_hs) begin
      skid_data_d  = s_tdata;
      skid_user_d  = s_tuser;
      skid_last_d  = s_tlast;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  // Slice registers; reset empties both entries and opens the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_user_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_user_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_user_q   <= out_user_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_user_q  <= skid_user_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign s_tready = in_ready_q;
  assign m_tdata  = out_data_q;
  assign m_tuser  = out_user_q;
  assign m_tlast  = out_last_q;
  assign m_tvalid = out_valid_q;

endmodule

// File: rtl/axi4s_pkt_arbiter.sv
// Packet-granular round-robin arbiter: N_SRC AXI4-Stream sources share one
// registered master port. A grant is held from the first accepted beat of a
// packet through its tlast beat; one IDLE cycle separates packets.
module axi4s_pkt_arbiter
  import axi4s_arb_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 64,
  parameter int SRC_W  = (N_SRC < 2) ? 1 : $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC*DATA_W-1:0] s_tdata,
  input  logic [N_SRC-1:0]        s_tvalid,
  input  logic [N_SRC-1:0]        s_tlast,
  output logic [N_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic [SRC_W-1:0]        m_tid,
  input  logic                    m_tready,
  output logic                    busy
);

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [MAX_SRC-1:0] req_pad;
  rr_pick_t           pick;

  logic [DATA_W-1:0] slice_in_data;
  logic              slice_in_last;
  logic              slice_in_valid;
  logic              slice_in_ready;
  logic              grant_hs;

  // Requests widened to the search width of rr_pick, then searched from rr_ptr+1.
  always_comb begin
    req_pad             = '0;
    req_pad[N_SRC-1:0]  = s_tvalid;
    pick                = rr_pick(req_pad, 4'(rr_ptr_q), N_SRC);
  end

  // Granted source is steered into the slice; only it sees ready.
  always_comb begin
    slice_in_valid = 1'b0;
    slice_in_data  = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
    slice_in_last  = s_tlast[grant_q];
    s_tready       = '0;
    if (state_q == ST_BUSY) begin
      slice_in_valid    = s_tvalid[grant_q];
      s_tready[grant_q] = slice_in_ready;
    end
    grant_hs = slice_in_valid && slice_in_ready;
  end

  // Next state: IDLE picks the next requester; BUSY holds the grant until
  // the tlast beat is accepted, then parks the pointer on the finished source.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          grant_d = SRC_W'(pick.idx);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (grant_hs && slice_in_last) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers; pointer resets to the last source so that the
  // first search after reset starts at source 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= SRC_W'(N_SRC - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign busy = (state_q == ST_BUSY);

  axis_reg_slice #(
    .DATA_W (DATA_W),
    .USER_W (SRC_W)
  ) u_slice (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (slice_in_data),
    .s_tuser  (grant_q),
    .s_tlast  (slice_in_last),
    .s_tvalid (slice_in_valid),
    .s_tready (slice_in_ready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tid),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

endmodule

// File: tb/tb_axi4s_pkt_arbiter.sv
// Randomised bench for axi4s_pkt_arbiter with a packet-level round-robin
// reference model and an output scoreboard.
module tb_axi4s_pkt_arbiter;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int TMO = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic [1:0]      m_tid;
  logic            m_tready;
  logic            busy;

  axi4s_pkt_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [1:0]    id;
  } beat_t;

  beat_t       exp_q[$];
  logic [DW-1:0] sd [N][$];
  logic        sl [N][$];
  int          pos [N];
  int          mdl_ptr;
  int          n_vec = 0;
  int          n_err = 0;
  int          first_out, last_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast",  64'(m_tlast),  64'd0);
    chk("rst_m_tdata",  m_tdata,       64'd0);
    chk("rst_m_tid",    64'(m_tid),    64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    rst = 1'b0;
    mdl_ptr = N - 1;
  endtask

  // Builds per-source packet queues and the expected output order: at every
  // arbitration all sources with packets left are requesting, so the order
  // is plain round robin over non-empty sources starting after mdl_ptr.
  task automatic gen(input logic [N-1:0] mask, input int npkt, input int minlen,
                     input int maxlen, input bit incr);
    int rem [N];
    int mp [N];
    int pick;
    int len;
    bit found;
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      sd[i].delete();
      sl[i].delete();
      pos[i] = 0;
      mp[i]  = 0;
      rem[i] = mask[i] ? npkt : 0;
      for (int p = 0; p < rem[i]; p++) begin
        len = $urandom_range(maxlen, minlen);
        for (int k = 0; k < len; k++) begin
          sd[i].push_back(incr ? DW'(k) : {$urandom, $urandom});
          sl[i].push_back(k == len - 1);
        end
      end
    end
    forever begin
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && rem[(mdl_ptr + k) % N] > 0) begin
          found = 1'b1;
          pick  = (mdl_ptr + k) % N;
        end
      end
      if (!found) break;
      do begin
        b.d  = sd[pick][mp[pick]];
        b.l  = sl[pick][mp[pick]];
        b.id = 2'(pick);
        exp_q.push_back(b);
        mp[pick]++;
      end while (!b.l);
      rem[pick]--;
      mdl_ptr = pick;
    end
  endtask

  // Cycle loop: drive at negedge, sample 1 ns later, check handshakes,
  // one-hot ready, idle bubble after tlast, and stall stability.
  task automatic run(input logic [N-1:0] mask, input int gap_pct, input int rdy_pct);
    logic [N-1:0] held;
    bit           prev_stall, prev_tlast_hs, tlast_hs;
    logic [DW-1:0] pd;
    logic         pl;
    logic [1:0]   pid;
    int           cyc;
    bit           start;
    beat_t        e;
    held = '0; prev_stall = 0; prev_tlast_hs = 0; cyc = 0;
    pd = '0; pl = 1'b0; pid = '0;
    first_out = -1; last_out = -1;
    while (exp_q.size() > 0 && cyc < TMO) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (pos[i] < sd[i].size()) begin
          start = (pos[i] == 0) || sl[i][pos[i]-1];
          s_tvalid[i] = held[i] || start || ($urandom_range(99, 0) >= gap_pct);
          s_tdata[i*DW +: DW] = sd[i][pos[i]];
          s_tlast[i] = sl[i][pos[i]];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tdata[i*DW +: DW] = '0;
          s_tlast[i] = 1'b0;
        end
      end
      m_tready = ($urandom_range(99, 0) < rdy_pct);
      #1;
      chk("s_tready_onehot0", 64'($countones(s_tready) <= 1), 64'd1);
      chk("s_tready_mask", 64'(s_tready & ~mask), 64'd0);
      if (prev_tlast_hs) begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_s_tready", 64'(s_tready), 64'd0);
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", m_tdata, pd);
        chk("hold_last", 64'(m_tlast), 64'(pl));
        chk("hold_tid", 64'(m_tid), 64'(pid));
      end
      tlast_hs = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          tlast_hs = tlast_hs | s_tlast[i];
          pos[i]++;
          held[i] = 1'b0;
        end else begin
          held[i] = s_tvalid[i];
        end
      end
      if (m_tvalid && m_tready) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        e = exp_q.pop_front();
        chk("out_data", m_tdata, e.d);
        chk("out_last", 64'(m_tlast), 64'(e.l));
        chk("out_tid", 64'(m_tid), 64'(e.id));
      end
      prev_tlast_hs = tlast_hs;
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pl = m_tlast; pid = m_tid;
      cyc++;
    end
    chk("timeout", 64'(cyc < TMO), 64'd1);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_m_tvalid", 64'(m_tvalid), 64'd0);
  endtask

  initial begin
    int acc;
    int cyc;
    rst = 1'b1;
    idle_inputs();
    apply_reset();

    // Source 0 alone, 8 beats 0..7, downstream always ready.
    gen(4'b0001, 1, 8, 8, 1'b1);
    run(4'b0001, 0, 100);
    chk("lat_first_out", 64'(first_out), 64'd2);
    chk("lat_last_out", 64'(last_out), 64'd9);

    // Sources 0 and 1 alternate.
    gen(4'b0011, 3, 8, 8, 1'b0);
    run(4'b0011, 0, 100);

    // Sources 1 and 3 alternate; 0 and 2 never see ready.
    gen(4'b1010, 3, 8, 8, 1'b0);
    run(4'b1010, 0, 100);

    // Downstream back-pressure on a single source.
    gen(4'b0001, 2, 8, 12, 1'b0);
    run(4'b0001, 0, 40);

    // Back-to-back 1-beat packets from every source (after reset: 0,1,2,3).
    apply_reset();
    gen(4'b1111, 2, 1, 1, 1'b0);
    run(4'b1111, 0, 100);

    // Random mix: gaps inside packets and random back-pressure.
    gen(4'b1111, 4, 1, 6, 1'b0);
    run(4'b1111, 30, 60);
    gen(4'b0110, 5, 1, 9, 1'b0);
    run(4'b0110, 20, 80);

    // Reset in the middle of a source-2 packet.
    apply_reset();
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 50) begin
      @(negedge clk);
      s_tvalid    = 4'b0100;
      s_tlast     = 4'b0000;
      s_tdata     = '0;
      s_tdata[2*DW +: DW] = DW'(acc);
      m_tready    = 1'b1;
      #1;
      if (s_tready[2]) acc++;
      cyc++;
    end
    chk("midrst_progress", 64'(acc), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    idle_inputs();
    mdl_ptr = N - 1;
    gen(4'b1111, 1, 2, 2, 1'b0);
    chk("midrst_first_tid_model", 64'(exp_q[0].id), 64'd0);
    run(4'b1111, 0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
